// File: rtl/reset_seq_if.sv
// Reset sequencer bus: lock/soft-reset requests in,
// staged resets, ready and cause out.
interface reset_seq_if #(
  parameter int NCH = 3
);
  logic           pll_locked;
  logic           sw_reset;
  logic [NCH-1:0] rst_out;
  logic           ready;
  logic [1:0]     cause;

  modport master (
    input  pll_locked,
    input  sw_reset,
    output rst_out,
    output ready,
    output cause
  );

  modport slave (
    output pll_locked,
    output sw_reset,
    input  rst_out,
    input  ready,
    input  cause
  );
endinterface

// File: rtl/reset_seq.sv
// Staged reset sequencer: waits for a stable PLL lock,
// releases channels in ascending order, handles soft reset.
module reset_seq #(
  parameter int NCH         = 3,
  parameter int SYNC_STAGES = 2,
  parameter int POR_CYCLES  = 63,
  parameter int STAGE_GAP   = 16,
  parameter int MIN_ASSERT  = 32
) (
  input  logic        clk50,
  input  logic        resetbtn,
  reset_seq_if.master bus
);

  localparam int GAPS = NCH * STAGE_GAP;
  localparam int CM0  = (POR_CYCLES > GAPS) ? POR_CYCLES : GAPS;
  localparam int CMAX = (CM0 > MIN_ASSERT) ? CM0 : MIN_ASSERT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] C_POR = CW'(POR_CYCLES);
  localparam logic [CW-1:0] C_REL = CW'(GAPS);
  localparam logic [CW-1:0] C_MIN = CW'(MIN_ASSERT);

  typedef enum logic [1:0] {
    HOLD, RELEASE, RUN, SOFT
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [NCH-1:0]         rst_q, rst_d;
  logic                   ready_q, ready_d;
  logic [1:0]             cause_q, cause_d;
  logic                   lock_s;
  logic                   lock_lost;
  logic                   soft_req;

  assign lock_s  = sync_q[SYNC_STAGES-1];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  assign lock_lost = (state_q != HOLD) && !lock_s;
  assign soft_req  = ((state_q == RELEASE) || (state_q == RUN))
                   && lock_s && bus.sw_reset;

  always_ff @(posedge clk50 or negedge resetbtn) begin
    if (!resetbtn) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      sync_q  <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
      rst_q   <= rst_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    unique case (state_q)
      HOLD: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_inc == C_POR) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (lock_lost) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (soft_req) begin
          state_d = SOFT;
          cnt_d   = '0;
        end else if (cnt_inc == C_REL) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (lock_lost) begin
          state_d = HOLD;
        end else if (soft_req) begin
          state_d = SOFT;
        end
      end
      SOFT: begin
        if (lock_lost) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (bus.sw_reset) begin
          cnt_d = '0;
        end else if (cnt_inc == C_MIN) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Channel k drops once the release count reaches (k+1)*STAGE_GAP.
  always_comb begin
    rst_d   = '1;
    ready_d = 1'b0;
    cause_d = cause_q;
    if (lock_lost) begin
      cause_d = 2'd1;
    end else if (soft_req) begin
      cause_d = 2'd2;
    end
    unique case (1'b1)
      (state_d == RUN): begin
        rst_d   = '0;
        ready_d = 1'b1;
      end
      (state_d == RELEASE && state_q == RELEASE): begin
        for (int k = 0; k < NCH; k++) begin
          rst_d[k] = rst_q[k]
                   & (int'(cnt_inc) < (k + 1) * STAGE_GAP);
        end
      end
      default: ;
    endcase
  end

  assign bus.rst_out = rst_q;
  assign bus.ready   = ready_q;
  assign bus.cause   = cause_q;

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter NCH, default 3: number of staged reset outputs (1..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for pll_locked (>=2).
REQ-003 SHALL have parameter POR_CYCLES, default 63: consecutive synchronised-lock cycles required before release (>=1).
REQ-004 SHALL have parameter STAGE_GAP, default 16: cycles between successive channel releases (>=1).
REQ-005 SHALL have parameter MIN_ASSERT, default 32: minimum assertion cycles for a soft reset (>=1).
REQ-006 SHALL have port clk50  input  1  sole clock.
REQ-007 SHALL have port resetbtn  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port pll_locked  input  1  PLL lock; asynchronous to clk50.
REQ-009 SHALL have port sw_reset  input  1  synchronous soft-reset request, sampled each cycle.
REQ-010 SHALL have port rst_out  output  NCH  active-high resets; bit 0 released first.
REQ-011 SHALL have port ready  output  1  high only when all channels are released.
REQ-012 SHALL have port cause  output  2  last reset cause: 0 POR/button, 1 lock lost, 2 soft, 3 unused.

Function
REQ-013 SHALL pass pll_locked through a SYNC_STAGES flop chain; lock_s (last stage) is the only lock value used internally.
REQ-014 SHALL implement states HOLD, RELEASE, RUN, SOFT; all outputs registered.
REQ-015 HOLD: rst_out all ones, ready 0; counter increments while lock_s=1 and clears to 0 whenever lock_s=0.
REQ-016 HOLD->RELEASE on the edge where the counter reaches POR_CYCLES; counter cleared.
REQ-017 RELEASE: channel k SHALL deassert exactly (k+1)*STAGE_GAP cycles after the entry edge; released channels stay low.
REQ-018 RELEASE->RUN on the edge channel NCH-1 deasserts; ready rises on that same edge.
REQ-019 RUN: rst_out all zeros, ready 1, held until an event in REQ-020/REQ-021.
REQ-020 In RELEASE, RUN or SOFT, lock_s=0 SHALL on the next edge re-assert all rst_out bits, clear ready, set cause=1, enter HOLD, and clear counters.
REQ-021 In RELEASE or RUN with lock_s=1, sw_reset=1 SHALL on the next edge re-assert all rst_out bits, clear ready, set cause=2, enter SOFT, and clear the counter.
REQ-022 Lock loss SHALL take priority over sw_reset when both are active in the same cycle.
REQ-023 SOFT: all asserted; counter counts every cycle; sw_reset re-asserted in SOFT restarts the count at 0; SOFT->RELEASE when the counter reaches MIN_ASSERT.
REQ-024 sw_reset in HOLD SHALL be ignored and SHALL leave cause unchanged.
REQ-025 Counter width SHALL be clog2(max(POR_CYCLES,NCH*STAGE_GAP,MIN_ASSERT)+1); counters SHALL saturate and never wrap.
REQ-026 rst_out SHALL never contain a released channel whose index exceeds that of an asserted channel; release order SHALL be strictly ascending.

Reset
REQ-027 resetbtn=0 SHALL immediately (asynchronously) force rst_out all ones, ready 0, cause 0, state HOLD, and all counters and synchroniser flops 0.
REQ-028 Deassertion of resetbtn SHALL not itself release any channel; release follows REQ-015..018 only.
REQ-029 Asserting resetbtn mid-RELEASE or mid-SOFT SHALL abort the sequence with the values of REQ-027.

Verification (NCH=3, SYNC_STAGES=2, POR_CYCLES=4, STAGE_GAP=2, MIN_ASSERT=3)
REQ-030 Power-up: resetbtn released at edge 0 with pll_locked=1 -> lock_s=1 at edge 2; RELEASE entered at edge 6; rst_out 110 at edge 8, 100 at 10, 000 at 12 with ready=1 at 12; cause=0 throughout.
REQ-031 Lock glitch: pll_locked low for 1 cycle during the HOLD count -> counter clears; release occurs 4 lock_s cycles after lock_s returns high.
REQ-032 Soft reset in RUN: sw_reset pulsed for 1 cycle -> next edge rst_out=111, ready=0, cause=2; RELEASE 3 cycles later; staged release completes 6 cycles after that.
REQ-033 Lock loss in RUN with sw_reset high in the same cycle -> next edge rst_out=111, cause=1, state HOLD, no SOFT entry.
REQ-034 resetbtn asserted asynchronously mid-RELEASE (rst_out=110) -> rst_out=111, ready=0 and cause=0 before the next clock edge.
REQ-035 Random pll_locked/sw_reset stress: REQ-026 ordering and "ready=1 iff rst_out==0" checked every cycle.
